// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, tagFree, unit indices and round-robin helper for the writeback arbiter
package wb_arbiter_pkg;
    localparam int NREQ   = 3;
    localparam int DEPTH  = 2;
    localparam int NAME_W = 5;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int ENT_W  = NAME_W + TAG_W + DATA_W;
    localparam int PW     = $clog2(NREQ);
    localparam logic [TAG_W-1:0] TAG_FREE = '1;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    typedef enum logic [1:0] {UNIT_ALU, UNIT_BR, UNIT_MUL} unit_e;
    typedef struct packed {
        logic [NAME_W-1:0] name;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } wb_ent_t;
    function automatic logic [PW-1:0] rr_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return PW'(s >= NREQ ? s - NREQ : s);
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small per-requester result FIFO with registered pointers and count
module wb_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt;
    assign full  = r_cnt == CW'(DEPTH);
    assign empty = r_cnt == '0;
    assign head  = r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(push);
            r_rd  <= r_rd + AW'(pop);
            r_cnt <= r_cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push) r_mem[r_wr] <= din;
    always_ff @(posedge clk)
        if (!rst) assert (!(push && full));
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback scheduler driving a registered result broadcast
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NREQ-1:0]          in_valid,
    output logic [NREQ-1:0]          in_ready,
    input  logic [NREQ*NAME_W-1:0]   in_name,
    input  logic [NREQ*TAG_W-1:0]    in_tag,
    input  logic [NREQ*DATA_W-1:0]   in_data,
    output logic                     wb_en,
    output logic [NAME_W-1:0]        wb_name,
    output logic [TAG_W-1:0]         wb_tag,
    output logic [DATA_W-1:0]        wb_data
);
    logic [NREQ-1:0] w_push, w_pop, w_full, w_empty;
    logic [ENT_W-1:0] w_head [NREQ];
    logic w_gnt_v;
    logic [PW-1:0] w_gnt, r_rr;
    assign in_ready = (rst || flush) ? '0 : ~w_full;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = w_gnt_v ? NREQ'(1) << w_gnt : '0;
    for (genvar i = 0; i < NREQ; i++) begin : g_fifo
        wb_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clear (flush),
            .push  (w_push[i]),
            .pop   (w_pop[i]),
            .din   ({in_name[i*NAME_W +: NAME_W], in_tag[i*TAG_W +: TAG_W], in_data[i*DATA_W +: DATA_W]}),
            .head  (w_head[i]),
            .full  (w_full[i]),
            .empty (w_empty[i])
        );
    end
    // scan from the far end so the candidate closest to r_rr is assigned last and wins
    always_comb begin
        w_gnt_v = 1'b0;
        w_gnt   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (!w_empty[rr_add(r_rr, k)]) begin
                w_gnt_v = 1'b1;
                w_gnt   = rr_add(r_rr, k);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr    <= '0;
            wb_en   <= DISABLE;
            wb_name <= '0;
            wb_tag  <= TAG_FREE;
            wb_data <= '0;
        end else if (flush) begin
            wb_en <= DISABLE;
        end else begin
            wb_en <= w_gnt_v;
            if (w_gnt_v) begin
                {wb_name, wb_tag, wb_data} <= w_head[w_gnt];
                r_rr <= rr_add(w_gnt, 1);
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed checks of wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst, flush;
    logic [NREQ-1:0] in_valid, in_ready;
    logic [NREQ*NAME_W-1:0] in_name;
    logic [NREQ*TAG_W-1:0] in_tag;
    logic [NREQ*DATA_W-1:0] in_data;
    logic wb_en;
    logic [NAME_W-1:0] wb_name;
    logic [TAG_W-1:0] wb_tag;
    logic [DATA_W-1:0] wb_data;
    int n_chk = 0;
    int n_bad = 0;
    wb_ent_t q [NREQ][$];
    int rr;
    logic m_en;
    logic [NAME_W-1:0] m_name;
    logic [TAG_W-1:0] m_tag;
    logic [DATA_W-1:0] m_data;
    logic [NREQ-1:0] last_acc;
    wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_name(in_name), .in_tag(in_tag), .in_data(in_data),
        .wb_en(wb_en), .wb_name(wb_name), .wb_tag(wb_tag), .wb_data(wb_data)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic set_in(input int i, input logic [31:0] n, input logic [31:0] t, input logic [31:0] d);
        in_valid[i] = 1'b1;
        in_name[i*NAME_W +: NAME_W] = NAME_W'(n);
        in_tag[i*TAG_W +: TAG_W] = TAG_W'(t);
        in_data[i*DATA_W +: DATA_W] = d;
    endtask
    // one clock: check in_ready, advance the model by the specified rules, check the broadcast
    task automatic tick();
        logic [NREQ-1:0] rdy;
        int g;
        wb_ent_t e;
        #1;
        for (int i = 0; i < NREQ; i++) rdy[i] = !rst && !flush && q[i].size() < DEPTH;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        last_acc = '0;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) q[i].delete();
            rr = 0; m_en = 0; m_name = '0; m_tag = '1; m_data = '0;
        end else if (flush) begin
            for (int i = 0; i < NREQ; i++) q[i].delete();
            m_en = 0;
        end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && q[(rr + k) % NREQ].size() != 0) g = (rr + k) % NREQ;
            m_en = (g >= 0);
            if (g >= 0) begin
                e = q[g].pop_front();
                m_name = e.name; m_tag = e.tag; m_data = e.data;
                rr = (g + 1) % NREQ;
            end
            for (int i = 0; i < NREQ; i++)
                if (in_valid[i] && rdy[i]) begin
                    e.name = in_name[i*NAME_W +: NAME_W];
                    e.tag = in_tag[i*TAG_W +: TAG_W];
                    e.data = in_data[i*DATA_W +: DATA_W];
                    q[i].push_back(e);
                    last_acc[i] = 1'b1;
                end
        end
        @(posedge clk);
        #1;
        chk("wb_en", 64'(wb_en), 64'(m_en));
        chk("wb_name", 64'(wb_name), 64'(m_name));
        chk("wb_tag", 64'(wb_tag), 64'(m_tag));
        chk("wb_data", 64'(wb_data), 64'(m_data));
        @(negedge clk);
    endtask
    initial begin
        int t;
        rst = 1'b1; flush = 1'b0; in_valid = '0; in_name = '0; in_tag = '0; in_data = '0;
        @(negedge clk);
        tick(); tick();
        chk("reset_tag_free", 64'(wb_tag), 64'hF);
        rst = 1'b0;
        tick();
        set_in(1, 5, 3, 32'hDEADBEEF);
        tick();
        in_valid = '0;
        repeat (4) tick();
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NREQ; i++) set_in(i, i, c, $urandom);
            tick();
        end
        in_valid = '0;
        repeat (8) tick();
        t = 1;
        for (int c = 0; c < 40 && t <= 4; c++) begin
            set_in(0, 0, t, t);
            set_in(1, 1, 8, $urandom);
            set_in(2, 2, 9, $urandom);
            tick();
            if (last_acc[0]) t++;
        end
        chk("order_all_pushed", 64'(t), 64'd5);
        in_valid = '0;
        repeat (8) tick();
        for (int i = 0; i < NREQ; i++) set_in(i, i + 10, i, $urandom);
        tick();
        in_valid = '0;
        set_in(0, 20, 5, $urandom);
        set_in(1, 21, 6, $urandom);
        tick();
        set_in(2, 22, 10, $urandom);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = '0;
        tick();
        set_in(2, 9, 7, 32'h77);
        tick();
        in_valid = '0;
        repeat (3) tick();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NREQ; i++) set_in(i, i, c + 1, $urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = '0;
        repeat (4) tick();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            flush = !rst && ($urandom_range(0, 29) == 0);
            in_valid = NREQ'($urandom);
            in_name = NREQ*NAME_W'($urandom);
            in_tag = NREQ*TAG_W'($urandom);
            for (int i = 0; i < NREQ; i++) in_data[i*DATA_W +: DATA_W] = $urandom;
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = '0;
        repeat (8) tick();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
